// File: rtl/clock_pkg.sv
// clock_pkg: ASCII constants, time snapshot type, UART FSM states and message byte mapping.
package clock_pkg;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam int MSG_LEN = 10;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

    typedef struct packed {
        logic [1:0] hourtens;
        logic [3:0] hourunits;
        logic [2:0] mintens;
        logic [3:0] minunits;
        logic [2:0] sectens;
        logic [3:0] secunits;
    } time_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return d > 4'd9 ? ASCII_QMARK : ASCII_ZERO + {4'b0, d};
    endfunction

    function automatic logic [7:0] msg_byte(input time_t t, input logic [3:0] i);
        case (i)
            4'd0:    return digit_ascii({2'b0, t.hourtens});
            4'd1:    return digit_ascii(t.hourunits);
            4'd3:    return digit_ascii({1'b0, t.mintens});
            4'd4:    return digit_ascii(t.minunits);
            4'd6:    return digit_ascii({1'b0, t.sectens});
            4'd7:    return digit_ascii(t.secunits);
            4'd2,
            4'd5:    return ASCII_COLON;
            4'd8:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction
endpackage

// File: rtl/time_uart_tx_if.sv
// time_uart_tx_if: time digits and send request in, serial line and status out.
interface time_uart_tx_if;
    logic       send;
    logic [1:0] hourtens;
    logic [3:0] hourunits;
    logic [2:0] mintens;
    logic [3:0] minunits;
    logic [2:0] sectens;
    logic [3:0] secunits;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output send, hourtens, hourunits, mintens, minunits, sectens, secunits,
                    input tx, busy, done);
    modport slave  (input send, hourtens, hourunits, mintens, minunits, sectens, secunits,
                    output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer; ready also rises on the last stop cycle so bytes chain gaplessly.
module uart_tx_byte
    import clock_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);
    localparam int CW = $clog2(DIV);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          last;

    assign last  = cnt_q == CW'(DIV - 1);
    assign ready = state_q == IDLE || (state_q == STOP && last);
    assign tx    = tx_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: if (load) begin
                state_d = START;
                tx_d    = 1'b0;
                shift_d = data;
            end
            START: if (last) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (last) begin
                state_d = bit_q == 3'd7 ? STOP : DATA;
                bit_d   = bit_q + 1'b1;
                shift_d = shift_q >> 1;
                tx_d    = bit_q == 3'd7 ? 1'b1 : shift_q[1];
            end
            STOP: if (last) begin
                state_d = load ? START : IDLE;
                tx_d    = ~load;
                shift_d = load ? data : shift_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: rtl/time_uart_tx.sv
// time_uart_tx: on send, snapshots the time and transmits "HH:MM:SS\r\n" as 8N1 UART.
module time_uart_tx
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input logic clk,
    input logic rst,
    time_uart_tx_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

    time_t      snap_q, snap_d, cur;
    logic [3:0] idx_q, idx_d;
    logic       busy_q, busy_d, done_q, done_d;
    logic       accept, next_byte, finish, load, ready, tx;
    logic [7:0] data;

    assign cur = '{bus.hourtens, bus.hourunits, bus.mintens, bus.minunits, bus.sectens, bus.secunits};

    // Byte 0 is loaded on the accept edge itself, straight from the live inputs.
    always_comb begin
        accept    = bus.send & ~busy_q;
        next_byte = busy_q & ready & (idx_q != LAST_IDX);
        finish    = busy_q & ready & (idx_q == LAST_IDX);
        load      = accept | next_byte;
        snap_d    = accept ? cur : snap_q;
        idx_d     = accept ? 4'd0 : next_byte ? idx_q + 4'd1 : finish ? 4'd0 : idx_q;
        busy_d    = accept | (busy_q & ~finish);
        done_d    = finish;
        data      = msg_byte(snap_d, idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_q <= '0;
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_byte (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .tx    (tx),
        .ready (ready)
    );

    assign bus.tx   = tx;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_time_uart_tx.sv
// tb_time_uart_tx: scoreboard bench; a mid-bit line decoder pops expected bytes per received frame.
module tb_time_uart_tx;
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];
    logic [7:0] mb, exp_b;
    logic ms;
    bit ab;
    int cnt;

    time_uart_tx_if bus();

    time_uart_tx #(.CLK_HZ(1600), .BAUD(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_time(input logic [1:0] ht, input logic [3:0] hu, input logic [2:0] mt,
                            input logic [3:0] mu, input logic [2:0] st, input logic [3:0] su);
        bus.hourtens = ht; bus.hourunits = hu; bus.mintens = mt;
        bus.minunits = mu; bus.sectens = st; bus.secunits = su;
    endtask

    task automatic expect_msg(input string s);
        for (int i = 0; i < s.len(); i++) sb.push_back(s[i]);
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
    endtask

    task automatic start_msg(input string s);
        expect_msg(s);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("accept_tx", bus.tx, 0);
    endtask

    task automatic track(output int n, output int dones);
        n = 0;
        dones = 0;
        while (bus.busy && n < 2000) begin
            n++;
            if (bus.done) dones++;
            @(negedge clk);
        end
    endtask

    task automatic finish_checks(input string name, input int n, input int dones);
        check({name, "_busy_cycles"}, n, 1600);
        check({name, "_done_while_busy"}, dones, 0);
        check({name, "_done_at_fall"}, bus.done, 1);
        check({name, "_tx_idle"}, bus.tx, 1);
        @(negedge clk);
        check({name, "_done_single"}, bus.done, 0);
    endtask

    // Line decoder: start seen at a negedge, data bit j sampled 24+16j cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.tx === 1'b0) begin
                ab = 1'b0;
                for (int c = 1; c <= 152; c++) begin
                    @(negedge clk);
                    if (rst) ab = 1'b1;
                    if (c >= 24 && c <= 136 && c % 16 == 8) mb[(c - 24) / 16] = bus.tx;
                    if (c == 152) ms = bus.tx;
                end
                if (!ab) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_byte: got %0h expected none", mb);
                    end else begin
                        exp_b = sb.pop_front();
                        check("byte", mb, exp_b);
                        check("stop_bit", ms, 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        rst = 1'b1;
        bus.send = 1'b0;
        set_time(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", bus.tx, 1);
            check("rst_busy", bus.busy, 0);
            check("rst_done", bus.done, 0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_tx", bus.tx, 1);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.done, 0);
        end

        set_time(1, 2, 3, 4, 5, 6);
        start_msg("12:34:56");
        track(cnt, dones);
        finish_checks("m1", cnt, dones);

        // Snapshot, busy rejection, send on the done edge then one cycle later.
        repeat (3) @(negedge clk);
        set_time(2, 3, 5, 9, 5, 9);
        start_msg("23:59:59");
        cnt = 0;
        while (bus.busy && cnt < 2000) begin
            cnt++;
            if (cnt == 340) set_time(0, 0, 0, 0, 0, 0);
            if (cnt == 500) bus.send = 1'b1;
            if (cnt == 501) bus.send = 1'b0;
            if (cnt == 1600) begin
                bus.send = 1'b1;
                expect_msg("00:00:00");
            end
            @(negedge clk);
        end
        check("m2_busy_cycles", cnt, 1600);
        check("m2_done", bus.done, 1);
        check("m2_send_on_done_ignored", bus.busy, 0);
        @(negedge clk);
        bus.send = 1'b0;
        check("m3_accept_busy", bus.busy, 1);
        check("m3_accept_tx", bus.tx, 0);
        track(cnt, dones);
        finish_checks("m3", cnt, dones);

        repeat (3) @(negedge clk);
        set_time(1, 2, 3, 4'hF, 5, 4'hA);
        start_msg("12:3?:5?");
        track(cnt, dones);
        finish_checks("m4", cnt, dones);

        // Abort in byte 5, data bit 3 (about cycle 800 + 64).
        repeat (3) @(negedge clk);
        set_time(1, 1, 1, 1, 1, 1);
        start_msg("11:11:11");
        repeat (868) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", bus.tx, 1);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("no_done_after_abort", dones, 0);
        set_time(0, 7, 0, 8, 0, 9);
        start_msg("07:08:09");
        track(cnt, dones);
        finish_checks("m5", cnt, dones);

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/time_uart_tx.md
# time_uart_tx

Serial time reporter for the digital clock/alarm design. On a request pulse it snapshots the six BCD time digits and transmits them over a UART TX line as the 10-byte ASCII message "HH:MM:SS\r\n", 8N1, LSB first. It is the outbound counterpart to the push-button/adjust input path: time leaves the board instead of entering it. The request is typically driven from the seconds-rollover strobe of the timekeeping counters.

## Interface
Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz
- BAUD, 115200, line rate; bit period DIV = CLK_HZ/BAUD cycles (integer, truncated; 868 at defaults); DIV >= 2 required

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- send  in  1  single-cycle request to transmit the current time
- hourtens  in  2  hours tens digit
- hourunits  in  4  hours units digit
- mintens  in  3  minutes tens digit
- minunits  in  4  minutes units digit
- sectens  in  3  seconds tens digit
- secunits  in  4  seconds units digit
- tx  out  1  UART serial output, idle high
- busy  out  1  high while a message is in progress
- done  out  1  one-cycle pulse at message completion

## Operation
- Reset values: tx=1, busy=0, done=0, FSM=IDLE, byte index=0, baud counter=0.
- send sampled only in IDLE; send while busy is ignored (no queueing).
- On accept, all six digits are registered into a snapshot; input changes afterward do not affect the message in flight.
- Message bytes, index 0..9: hourtens, hourunits, 0x3A, mintens, minunits, 0x3A, sectens, secunits, 0x0D, 0x0A.
- Digit to ASCII: 0x30 + zero-extended digit; any digit > 9 is sent as 0x3F ('?').
- Per-byte FSM: IDLE -> START (tx=0, DIV cycles) -> DATA (8 bits, LSB first, DIV cycles each) -> STOP (tx=1, DIV cycles) -> START for the next byte if index < 9, else IDLE.
- No idle gap between bytes: the next start bit begins the cycle after the previous stop bit ends.
- Baud counter counts 0..DIV-1 and resets at each bit boundary; bit count is 0..7 in DATA.

## Timing
- Accept at edge N (send=1, IDLE): tx=0 and busy=1 from edge N+1.
- Each bit lasts exactly DIV cycles; each byte lasts 10*DIV cycles; full message lasts 100*DIV cycles.
- Last stop bit ends at edge N+1+100*DIV: busy=0 and done=1 for exactly that cycle; tx stays 1.
- A send on the same cycle as done (busy still high in that cycle's registered state) is ignored; a send one cycle later is accepted.
- rst asserted mid-message: tx=1, busy=0, done=0 immediately (asynchronous); the partial message is abandoned; no done pulse. After release, the next send starts a fresh message at byte 0.
- done never asserts without a preceding accepted send.

## Structure
- Shared package (clock_pkg): ASCII constants (ASCII_ZERO 0x30, ASCII_COLON 0x3A, ASCII_QMARK 0x3F, ASCII_CR 0x0D, ASCII_LF 0x0A), MSG_LEN=10, and the per-byte FSM state encoding.
- One sub-module: uart_tx_byte (load strobe + 8-bit data in; tx, ready out; owns the baud counter, shift register and START/DATA/STOP sequencing). Top level owns the snapshot, byte index, ASCII mapping and busy/done.

## Test plan
Bench uses CLK_HZ=1600, BAUD=100 (DIV=16); the line decoder samples at mid-bit.
- Reset: hold rst 3 cycles -> tx=1, busy=0, done=0 throughout and after release with send=0.
- Time 12:34:56, single send -> decoded bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A; busy high for exactly 1600 cycles; done pulses once, on the cycle busy falls.
- Snapshot: send at 23:59:59, change inputs to 00:00:00 during byte 2 -> message still reads "23:59:59\r\n".
- Busy rejection: second send at cycle 500 of message -> ignored; send the cycle after done -> new message starts, tx=0 the following cycle.
- Invalid digit: secunits=0xA, minunits=0xF -> bytes 4 and 7 are 0x3F; other bytes are unaffected.
- Reset mid-byte: rst during DATA bit 3 of byte 5 -> tx=1, busy=0 same cycle, no done; a later send at 07:08:09 yields a complete, correct "07:08:09\r\n".
